weight_buf: RTL and testbench

Double-buffered (ping-pong) weight/bias holding register between the weight SRAM controller and the PE array. It collects the byte stream of one kernel or FC weight set, plus its bias, into a fill bank. It then presents the completed set in parallel to the PE array while the next set is fetched into the other bank. It also gives CONTROL back-pressure so a new SRAM read is only issued when a bank is free.

---
 rtl/weight_buf.sv | 118 +++++++++++
 tb/tb_weight_buf.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_buf.sv
// Ping-pong weight/bias buffer: one bank fills from the SRAM byte stream while
// the other presents a completed set to the PE array.
module weight_buf #(
   parameter int N_W = 25,
   parameter int DW  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_weight_new,
   input  logic              i_weight_new_16,
   input  logic              i_weight_new_8,
   input  logic [DW-1:0]     i_weight,
   input  logic              i_bias_new,
   input  logic [DW-1:0]     i_bias,
   input  logic              i_commit,
   input  logic              i_release,
   output logic              o_ready,
   output logic              o_valid,
   output logic [1:0]        o_mode,
   output logic [4:0]        o_count,
   output logic [N_W*DW-1:0] o_weights,
   output logic [DW-1:0]     o_bias,
   output logic              o_overflow
);

   localparam logic [4:0] N_MAX = 5'(N_W);

   logic [DW-1:0] ent    [2][N_W];
   logic [DW-1:0] bias_q [2];
   logic [1:0]    mode_q [2];
   logic [4:0]    cnt_q  [2];
   logic [1:0]    full_q;
   logic          wr_bank;
   logic          rd_bank;
   logic [4:0]    wr_idx;
   logic          first_q;
   logic          ovf_q;

   logic          wr_any;
   logic          fill_full;
   logic          wr_ok;
   logic          commit;
   logic          rel_ok;
   logic [1:0]    mode_in;

   assign wr_any    = i_weight_new | i_weight_new_16 | i_weight_new_8;
   assign fill_full = full_q[wr_bank];
   assign wr_ok     = wr_any && !fill_full && (wr_idx < N_MAX);
   assign commit    = i_bias_new | i_commit;
   assign rel_ok    = i_release && full_q[rd_bank];

   // conv outranks FC1, which outranks FC2, when flags coincide
   always_comb begin
      mode_in = 2'd2;
      if (i_weight_new)         mode_in = 2'd0;
      else if (i_weight_new_16) mode_in = 2'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < N_W; k++) ent[b][k] <= '0;
            bias_q[b] <= '0;
            mode_q[b] <= '0;
            cnt_q[b]  <= '0;
         end
         full_q  <= '0;
         wr_bank <= 1'b0;
         rd_bank <= 1'b0;
         wr_idx  <= '0;
         first_q <= 1'b1;
         ovf_q   <= 1'b0;
      end else begin
         // release needs the read bank full and writes need the fill bank
         // empty, so both can never touch the same bank in one cycle
         if (rel_ok) begin
            for (int k = 0; k < N_W; k++) ent[rd_bank][k] <= '0;
            bias_q[rd_bank] <= '0;
            mode_q[rd_bank] <= '0;
            cnt_q[rd_bank]  <= '0;
            full_q[rd_bank] <= 1'b0;
            rd_bank         <= ~rd_bank;
         end

         if (wr_ok) begin
            ent[wr_bank][wr_idx] <= i_weight;
            if (first_q) mode_q[wr_bank] <= mode_in;
         end

         if ((wr_any && !wr_ok) || (commit && fill_full)) ovf_q <= 1'b1;

         if (commit && !fill_full) begin
            bias_q[wr_bank] <= i_bias_new ? i_bias : '0;
            cnt_q[wr_bank]  <= wr_idx + {4'd0, wr_ok};
            full_q[wr_bank] <= 1'b1;
            wr_idx          <= '0;
            wr_bank         <= ~wr_bank;
            first_q         <= 1'b1;
         end else if (wr_ok) begin
            wr_idx  <= wr_idx + 5'd1;
            first_q <= 1'b0;
         end
      end
   end

   assign o_ready    = ~full_q[wr_bank];
   assign o_valid    = full_q[rd_bank];
   assign o_mode     = mode_q[rd_bank];
   assign o_count    = cnt_q[rd_bank];
   assign o_bias     = bias_q[rd_bank];
   assign o_overflow = ovf_q;

   always_comb begin
      o_weights = '0;
      for (int k = 0; k < N_W; k++) o_weights[DW*k +: DW] = ent[rd_bank][k];
   end

endmodule

// File: tb/tb_weight_buf.sv
// Bench for weight_buf: a queue-based set model feeds a scoreboard that is
// checked whenever the DUT presents a new set.
module tb_weight_buf;
   localparam int N_W = 25;
   localparam int DW  = 8;
   localparam int WW  = N_W*DW;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          i_weight_new = 0, i_weight_new_16 = 0, i_weight_new_8 = 0;
   logic [DW-1:0] i_weight = '0;
   logic          i_bias_new = 0;
   logic [DW-1:0] i_bias = '0;
   logic          i_commit = 0, i_release = 0;
   logic          o_ready, o_valid, o_overflow;
   logic [1:0]    o_mode;
   logic [4:0]    o_count;
   logic [WW-1:0] o_weights;
   logic [DW-1:0] o_bias;

   weight_buf #(.N_W(N_W), .DW(DW)) dut (
      .clk(clk), .rst(rst),
      .i_weight_new(i_weight_new), .i_weight_new_16(i_weight_new_16),
      .i_weight_new_8(i_weight_new_8), .i_weight(i_weight),
      .i_bias_new(i_bias_new), .i_bias(i_bias), .i_commit(i_commit),
      .i_release(i_release), .o_ready(o_ready), .o_valid(o_valid),
      .o_mode(o_mode), .o_count(o_count), .o_weights(o_weights),
      .o_bias(o_bias), .o_overflow(o_overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [WW-1:0] w;
      logic [DW-1:0] bias;
      logic [1:0]    mode;
      logic [4:0]    cnt;
   } set_t;

   set_t          exp_q[$];
   logic [DW-1:0] part[$];
   int            part_mode;
   int            held;
   bit            ovf;
   bit            checked;
   int            tests = 0;
   int            fails = 0;

   task automatic chk(input string nm, input logic [WW-1:0] act, input logic [WW-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // reference model: a set is a list of bytes; held counts committed sets
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         part.delete();
         exp_q.delete();
         part_mode = 0;
         held = 0;
         ovf = 0;
      end else begin
         bit   wr, com, rel;
         set_t s;
         wr  = i_weight_new | i_weight_new_16 | i_weight_new_8;
         com = i_bias_new | i_commit;
         rel = i_release && held > 0;
         if (held == 2) begin
            if (wr || com) ovf = 1;
         end else begin
            if (wr) begin
               if (part.size() < N_W) begin
                  if (part.size() == 0)
                     part_mode = i_weight_new ? 0 : (i_weight_new_16 ? 1 : 2);
                  part.push_back(i_weight);
               end else ovf = 1;
            end
            if (com) begin
               s.w = '0;
               foreach (part[k]) s.w[DW*k +: DW] = part[k];
               s.cnt  = 5'(part.size());
               s.mode = (part.size() > 0) ? 2'(part_mode) : 2'd0;
               s.bias = i_bias_new ? i_bias : '0;
               exp_q.push_back(s);
               part.delete();
               held++;
            end
         end
         if (rel) held--;
      end
   end

   // monitor: compares each newly presented set against the scoreboard
   always @(negedge clk) begin
      if (rst) checked = 0;
      else begin
         chk("ready", WW'(o_ready), WW'(held < 2));
         chk("overflow", WW'(o_overflow), WW'(ovf));
         chk("valid", WW'(o_valid), WW'(held > 0));
         if (o_valid && !checked) begin
            checked = 1;
            if (exp_q.size() == 0) chk("unexpected_set", WW'(1), WW'(0));
            else begin
               set_t e;
               e = exp_q.pop_front();
               chk("weights", o_weights, e.w);
               chk("bias", WW'(o_bias), WW'(e.bias));
               chk("mode", WW'(o_mode), WW'(e.mode));
               chk("count", WW'(o_count), WW'(e.cnt));
            end
         end
         if (i_release && o_valid) checked = 0;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      i_weight_new = 0; i_weight_new_16 = 0; i_weight_new_8 = 0;
      i_bias_new = 0; i_commit = 0; i_release = 0;
   endtask

   task automatic wbyte(input int kind, input logic [DW-1:0] v);
      i_weight_new    = (kind == 0);
      i_weight_new_16 = (kind == 1);
      i_weight_new_8  = (kind == 2);
      i_weight = v;
      step();
   endtask

   task automatic do_bias(input logic [DW-1:0] b);
      i_bias_new = 1; i_bias = b; step();
   endtask

   task automatic do_rel();
      i_release = 1; step();
   endtask

   task automatic do_reset();
      rst = 1; #3; rst = 0;
      step();
   endtask

   initial begin
      rst = 1;
      #12;
      chk("rst_ready", WW'(o_ready), WW'(1));
      chk("rst_valid", WW'(o_valid), WW'(0));
      chk("rst_weights", o_weights, '0);
      chk("rst_bias", WW'(o_bias), WW'(0));
      chk("rst_ovf", WW'(o_overflow), WW'(0));
      rst = 0;
      step();

      // conv set 0x01..0x19, bias 0x7F
      for (int k = 1; k <= 25; k++) wbyte(0, DW'(k));
      do_bias(8'h7F);
      chk("conv_valid", WW'(o_valid), WW'(1));
      chk("conv_count", WW'(o_count), WW'(25));
      chk("conv_e0", WW'(o_weights[7:0]), WW'(8'h01));
      chk("conv_e24", WW'(o_weights[199:192]), WW'(8'h19));
      chk("conv_bias", WW'(o_bias), WW'(8'h7F));
      chk("conv_ready", WW'(o_ready), WW'(1));
      do_rel();

      // FC2 set, committed without bias
      for (int k = 0; k < 16; k++) wbyte(2, DW'(8'hA0 + k));
      i_commit = 1; step();
      chk("fc2_count", WW'(o_count), WW'(16));
      chk("fc2_mode", WW'(o_mode), WW'(2));
      chk("fc2_bias", WW'(o_bias), WW'(0));
      chk("fc2_tail", WW'(o_weights[199:128]), WW'(0));
      do_rel();

      // ping-pong
      for (int k = 0; k < 3; k++) wbyte(0, DW'(k + 5));
      do_bias(8'h11);
      for (int k = 0; k < 2; k++) wbyte(1, DW'(k + 9));
      do_bias(8'h22);
      chk("pp_ready_full", WW'(o_ready), WW'(0));
      chk("pp_bias_a", WW'(o_bias), WW'(8'h11));
      do_rel();
      chk("pp_bias_b", WW'(o_bias), WW'(8'h22));
      chk("pp_ready_free", WW'(o_ready), WW'(1));
      do_rel();
      chk("pp_valid_off", WW'(o_valid), WW'(0));

      // commit and release in the same cycle
      wbyte(0, 8'h31); do_bias(8'h33);
      for (int k = 0; k < 3; k++) wbyte(1, DW'(8'h40 + k));
      i_weight_new_8 = 1; i_weight = 8'h43; i_bias_new = 1; i_bias = 8'h44; i_release = 1;
      step();
      chk("same_valid", WW'(o_valid), WW'(1));
      chk("same_bias", WW'(o_bias), WW'(8'h44));
      chk("same_count", WW'(o_count), WW'(4));
      chk("same_ready", WW'(o_ready), WW'(1));
      do_rel();

      // reset mid-fill, then an FC1 set
      for (int k = 0; k < 10; k++) wbyte(0, DW'(k + 1));
      rst = 1; #2;
      chk("mid_rst_ready", WW'(o_ready), WW'(1));
      chk("mid_rst_valid", WW'(o_valid), WW'(0));
      chk("mid_rst_count", WW'(o_count), WW'(0));
      #1; rst = 0;
      step();
      for (int k = 0; k < 8; k++) wbyte(1, DW'(8'h60 + k));
      i_commit = 1; step();
      chk("fc1_count", WW'(o_count), WW'(8));
      chk("fc1_mode", WW'(o_mode), WW'(1));
      do_rel();

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 9) > 3) begin
            int f;
            f = $urandom_range(1, 7);
            i_weight_new = f[0]; i_weight_new_16 = f[1]; i_weight_new_8 = f[2];
            i_weight = DW'($urandom);
         end
         if ($urandom_range(0, 11) == 0) begin
            int m;
            m = $urandom_range(0, 2);
            i_bias_new = (m != 1); i_commit = (m != 0); i_bias = DW'($urandom);
         end
         i_release = ($urandom_range(0, 5) == 0);
         step();
      end
      for (int g = 0; g < 10 && o_valid; g++) do_rel();
      chk("drain_valid", WW'(o_valid), WW'(0));
      chk("drain_sb_empty", WW'(exp_q.size()), WW'(0));

      // overflow: 26 bytes into a 25-entry bank
      do_reset();
      for (int k = 0; k < 26; k++) wbyte(0, DW'(k + 1));
      do_bias(8'h55);
      chk("ovf_count", WW'(o_count), WW'(25));
      chk("ovf_e24", WW'(o_weights[199:192]), WW'(8'h19));
      chk("ovf_flag", WW'(o_overflow), WW'(1));
      do_rel();
      do_rel();
      chk("ovf_sticky", WW'(o_overflow), WW'(1));
      chk("ovf_valid_off", WW'(o_valid), WW'(0));
      chk("end_sb_empty", WW'(exp_q.size()), WW'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
